op_dispatch: RTL and testbench



---
 rtl/op_dispatch.sv | 139 +++++++++++++
 tb/tb_op_dispatch.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/op_dispatch.sv
// op_dispatch: in-order opcode FIFO that routes its head opcode to green/blue/yellow by opcode[15:14].
// Latency: an opcode pushed at edge N into an empty FIFO is offered during cycle N+1; one opcode/cycle sustained.
// Backpressure: in_ready low when full or flushing; the head offer is sticky until accepted or flushed.
// Optional: define DISPATCH_STATS_EN to add per-unit 16-bit issue counters.
module op_dispatch #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [15:0]                in_op,
  output logic                       green_valid,
  output logic                       blue_valid,
  output logic                       yellow_valid,
  input  logic                       green_ready,
  input  logic                       blue_ready,
  input  logic                       yellow_ready,
  output logic [15:0]                out_op,
`ifdef DISPATCH_STATS_EN
  output logic [15:0]                cnt_green,
  output logic [15:0]                cnt_blue,
  output logic [15:0]                cnt_yellow,
`endif
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [LW-1:0] LVL_ONE = LW'(1);

  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;

  logic          w_empty;
  logic [15:0]   w_head;
  logic [1:0]    w_sel;
  logic          w_green_vld;
  logic          w_blue_vld;
  logic          w_yellow_vld;
  logic          w_in_ready;
  logic          w_push;
  logic          w_pop_green;
  logic          w_pop_blue;
  logic          w_pop_yellow;
  logic          w_pop;

  // Head decode: offers depend only on registered FIFO state, never on any *_ready.
  always_comb begin
    w_empty      = (r_level == '0);
    w_head       = r_mem[r_rd_ptr];
    w_sel        = w_head[15:14];
    w_green_vld  = ~w_empty & (w_sel == 2'b00);
    w_blue_vld   = ~w_empty & ((w_sel == 2'b01) | (w_sel == 2'b10));
    w_yellow_vld = ~w_empty & (w_sel == 2'b11);
    // No full-bypass: a same-cycle pop does not open a slot for the push.
    w_in_ready   = (r_level < DEPTH_L) & ~flush;
    w_push       = in_valid & w_in_ready;
    // Only the selected unit's ready can retire the head.
    w_pop_green  = w_green_vld & green_ready;
    w_pop_blue   = w_blue_vld & blue_ready;
    w_pop_yellow = w_yellow_vld & yellow_ready;
    w_pop        = w_pop_green | w_pop_blue | w_pop_yellow;
  end

  assign in_ready     = w_in_ready;
  assign green_valid  = w_green_vld;
  assign blue_valid   = w_blue_vld;
  assign yellow_valid = w_yellow_vld;
  assign out_op       = w_empty ? 16'h0000 : w_head;
  assign level        = r_level;

  // Storage array; stale entries are harmless since level gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_op;
    end
  end

  // Pointer and occupancy update; flush wins over push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

`ifdef DISPATCH_STATS_EN
  logic [15:0] r_cnt_green;
  logic [15:0] r_cnt_blue;
  logic [15:0] r_cnt_yellow;

  // Issue counters: count every pop per unit, wrap freely, survive flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_green  <= '0;
      r_cnt_blue   <= '0;
      r_cnt_yellow <= '0;
    end else begin
      if (w_pop_green) begin
        r_cnt_green <= r_cnt_green + 16'd1;
      end
      if (w_pop_blue) begin
        r_cnt_blue <= r_cnt_blue + 16'd1;
      end
      if (w_pop_yellow) begin
        r_cnt_yellow <= r_cnt_yellow + 16'd1;
      end
    end
  end

  assign cnt_green  = r_cnt_green;
  assign cnt_blue   = r_cnt_blue;
  assign cnt_yellow = r_cnt_yellow;
`endif

endmodule

// File: tb/tb_op_dispatch.sv
// Bench for op_dispatch: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_op_dispatch;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_op;
  logic        green_valid, blue_valid, yellow_valid;
  logic        green_ready, blue_ready, yellow_ready;
  logic [15:0] out_op;
  logic [2:0]  level;
`ifdef DISPATCH_STATS_EN
  logic [15:0] cnt_green, cnt_blue, cnt_yellow;
`endif

  always #5 clk = ~clk;

  op_dispatch #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .green_valid  (green_valid),
    .blue_valid   (blue_valid),
    .yellow_valid (yellow_valid),
    .green_ready  (green_ready),
    .blue_ready   (blue_ready),
    .yellow_ready (yellow_ready),
    .out_op       (out_op),
`ifdef DISPATCH_STATS_EN
    .cnt_green    (cnt_green),
    .cnt_blue     (cnt_blue),
    .cnt_yellow   (cnt_yellow),
`endif
    .level        (level)
  );

  // Reference model: the FIFO contents in order, plus per-unit issue tallies.
  logic [15:0] q[$];
  int          exp_cnt[3];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  // 0 = green, 1 = blue, 2 = yellow
  function automatic int unit_of(input logic [15:0] op);
    int top;
    top = int'(op >> 14);
    if (top == 0) return 0;
    if (top == 3) return 2;
    return 1;
  endfunction

  task automatic check_outs(input logic fl);
    int          u;
    logic [15:0] head;
    u    = -1;
    head = 16'h0000;
    if (q.size() > 0) begin
      head = q[0];
      u    = unit_of(head);
    end
    chk("green_valid",  32'(green_valid),  32'(u == 0));
    chk("blue_valid",   32'(blue_valid),   32'(u == 1));
    chk("yellow_valid", 32'(yellow_valid), 32'(u == 2));
    chk("out_op",       32'(out_op),       32'(head));
    chk("level",        32'(level),        32'(q.size()));
    chk("in_ready",     32'(in_ready),     32'((q.size() < DEPTH) && !fl));
`ifdef DISPATCH_STATS_EN
    chk("cnt_green",  32'(cnt_green),  exp_cnt[0] & 32'hFFFF);
    chk("cnt_blue",   32'(cnt_blue),   exp_cnt[1] & 32'hFFFF);
    chk("cnt_yellow", 32'(cnt_yellow), exp_cnt[2] & 32'hFFFF);
`endif
  endtask

  // One clock: drive inputs after the falling edge, check, then apply the model at the rising edge.
  task automatic cycle(input logic iv, input logic [15:0] op, input logic g, input logic b,
                       input logic y, input logic fl, output logic acc);
    logic do_pop, do_push;
    logic rdy[3];
    int   u;
    in_valid = iv; in_op = op; green_ready = g; blue_ready = b; yellow_ready = y; flush = fl;
    #1;
    check_outs(fl);
    rdy[0] = g; rdy[1] = b; rdy[2] = y;
    u       = (q.size() > 0) ? unit_of(q[0]) : 0;
    do_pop  = !fl && (q.size() > 0) && rdy[u];
    do_push = !fl && iv && (q.size() < DEPTH);
    acc     = do_push;
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (do_pop) begin
        void'(q.pop_front());
        exp_cnt[u]++;
      end
      if (do_push) q.push_back(op);
    end
    @(negedge clk);
  endtask

  initial begin
    logic acc;
    int   idx;
    logic tog;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = 16'h0;
    green_ready = 1'b0; blue_ready = 1'b0; yellow_ready = 1'b0;
    exp_cnt[0] = 0; exp_cnt[1] = 0; exp_cnt[2] = 0;
    repeat (2) @(negedge clk);
    check_outs(1'b0);
    rst_n = 1'b1;

    // Routing: one per unit class, all readies high
    cycle(1, 16'h0123, 1, 1, 1, 0, acc);
    cycle(1, 16'h4123, 1, 1, 1, 0, acc);
    cycle(1, 16'h8123, 1, 1, 1, 0, acc);
    cycle(1, 16'hC123, 1, 1, 1, 0, acc);
    repeat (2) cycle(0, 16'h0, 1, 1, 1, 0, acc);

    // Backpressure: fifth push must be refused, then drain in order
    for (int i = 0; i < 5; i++) cycle(1, 16'h4A00 + 16'(i), 1, 0, 1, 0, acc);
    repeat (5) cycle(0, 16'h0, 1, 1, 1, 0, acc);

    // Head-of-line hold: green head blocks yellow behind it
    cycle(1, 16'h0001, 0, 0, 1, 0, acc);
    cycle(1, 16'hC002, 0, 0, 1, 0, acc);
    repeat (5) cycle(0, 16'h0, 0, 1, 1, 0, acc);
    repeat (3) cycle(0, 16'h0, 1, 1, 1, 0, acc);

    // Flush priority: level 3, flush alongside a push and an accepting ready
    for (int i = 0; i < 3; i++) cycle(1, 16'h0100 + 16'(i), 0, 0, 0, 0, acc);
    cycle(1, 16'h0F0F, 1, 1, 1, 1, acc);
    cycle(0, 16'h0, 0, 0, 0, 0, acc);

    // Async reset mid-stream with two blue opcodes buffered
    cycle(1, 16'h4001, 0, 0, 0, 0, acc);
    cycle(1, 16'h4002, 0, 0, 0, 0, acc);
    in_valid = 1'b0; green_ready = 1'b0; blue_ready = 1'b0; yellow_ready = 1'b0; flush = 1'b0;
    #1;
    check_outs(1'b0);
    rst_n = 1'b0;
    #1;
    q.delete();
    exp_cnt[0] = 0; exp_cnt[1] = 0; exp_cnt[2] = 0;
    check_outs(1'b0);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    cycle(0, 16'h0, 0, 0, 0, 0, acc);

    // Wrap-around: ten green opcodes with green_ready toggling
    idx = 0;
    tog = 1'b0;
    for (int n = 0; n < 60 && (idx < 10 || q.size() > 0); n++) begin
      cycle(idx < 10, 16'(idx), tog, 0, 0, 0, acc);
      if (acc) idx++;
      tog = ~tog;
    end
    chk("wrap_pushed", 32'(idx), 32'd10);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(0, 1)), 16'($urandom),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0), acc);
    end
    repeat (6) cycle(0, 16'h0, 1, 1, 1, 0, acc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
